// File: rtl/drac_pkg.sv
// Shared types for the Lagarto load-response path: pending-load entry and tracker depth.
package drac_pkg;

    localparam int DCACHE_LD_PEND_DEPTH = 4;

    typedef enum logic [1:0] {
        LD_BYTE   = 2'd0,
        LD_HALF   = 2'd1,
        LD_WORD   = 2'd2,
        LD_DOUBLE = 2'd3
    } ld_size_t;

    // Payload kept per outstanding load; the killed flag lives in a separate reset vector.
    typedef struct packed {
        logic [2:0] offset;
        ld_size_t   size;
        logic       sign_ext;
        logic [4:0] rd;
    } ld_pend_entry_t;

endpackage

// File: rtl/lagarto_ld_align.sv
// Combinational load formatter: shifts the raw doubleword by the byte offset, then truncates and extends.
module lagarto_ld_align
    import drac_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  offset_i,
    input  ld_size_t    size_i,
    input  logic        sign_i,
    output logic [63:0] data_o
);

    logic [63:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = shifted;
        unique case (size_i)
            LD_BYTE:   data_o = {{56{sign_i & shifted[7]}},  shifted[7:0]};
            LD_HALF:   data_o = {{48{sign_i & shifted[15]}}, shifted[15:0]};
            LD_WORD:   data_o = {{32{sign_i & shifted[31]}}, shifted[31:0]};
            LD_DOUBLE: data_o = shifted;
            default:   data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lagarto_ld_resp_unit.sv
// In-order tracker for outstanding loads: records issue metadata, formats cache responses,
// drops responses belonging to flushed loads, and flags responses that arrive with nothing pending.
module lagarto_ld_resp_unit
    import drac_pkg::*;
#(
    parameter int DEPTH = DCACHE_LD_PEND_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ld_issue_valid_i,
    output logic        ld_issue_ready_o,
    input  logic [2:0]  ld_issue_offset_i,
    input  logic [1:0]  ld_issue_size_i,
    input  logic        ld_issue_signed_i,
    input  logic [4:0]  ld_issue_rd_i,
    input  logic        kill_i,
    input  logic        ld_resp_valid_i,
    input  logic [63:0] ld_resp_rdata_i,
    output logic        resp_valid_o,
    output logic [63:0] resp_data_o,
    output logic [4:0]  resp_rd_o,
    output logic        dmem_lock_o,
    output logic        spurious_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    ld_pend_entry_t entries_q [DEPTH];
    ld_pend_entry_t issue_entry;
    ld_pend_entry_t head;

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count;
    logic [DEPTH-1:0] killed_q, killed_d;
    logic             resp_valid_q, resp_valid_d;
    logic [63:0]      resp_data_q, resp_data_d;
    logic [4:0]       resp_rd_q, resp_rd_d;
    logic             spurious_q, spurious_d;

    logic        push, pop, head_dead;
    logic [63:0] aligned;

    assign count            = wr_ptr_q - rd_ptr_q;
    assign ld_issue_ready_o = (count < DEPTH_C);
    assign dmem_lock_o      = (count != '0);

    assign push = ld_issue_valid_i & ld_issue_ready_o & ~kill_i;
    assign pop  = ld_resp_valid_i & dmem_lock_o;

    assign head      = entries_q[rd_ptr_q[PW-1:0]];
    // A kill on the same edge as the pop still suppresses the head's result.
    assign head_dead = killed_q[rd_ptr_q[PW-1:0]] | kill_i;

    assign issue_entry.offset   = ld_issue_offset_i;
    assign issue_entry.size     = ld_size_t'(ld_issue_size_i);
    assign issue_entry.sign_ext = ld_issue_signed_i;
    assign issue_entry.rd       = ld_issue_rd_i;

    lagarto_ld_align u_align (
        .rdata_i  (ld_resp_rdata_i),
        .offset_i (head.offset),
        .size_i   (head.size),
        .sign_i   (head.sign_ext),
        .data_o   (aligned)
    );

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        killed_d     = killed_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        spurious_d   = spurious_q | (ld_resp_valid_i & ~dmem_lock_o);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            killed_d[wr_ptr_q[PW-1:0]] = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (!head_dead) begin
                resp_valid_d = 1'b1;
                resp_data_d  = aligned;
                resp_rd_d    = head.rd;
            end
        end
        // Marking free slots as well is harmless: a push clears its slot and never coincides with kill.
        if (kill_i) begin
            killed_d = '1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            killed_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            spurious_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            killed_q     <= killed_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            spurious_q   <= spurious_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            entries_q[wr_ptr_q[PW-1:0]] <= issue_entry;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_rd_o    = resp_rd_q;
    assign spurious_o   = spurious_q;

endmodule

// File: tb/tb_lagarto_ld_resp_unit.sv
// Directed bench for the load-response tracker with a queue-based scoreboard and a negedge monitor.
module tb_lagarto_ld_resp_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ld_issue_valid_i = 1'b0;
    logic        ld_issue_ready_o;
    logic [2:0]  ld_issue_offset_i = '0;
    logic [1:0]  ld_issue_size_i = '0;
    logic        ld_issue_signed_i = 1'b0;
    logic [4:0]  ld_issue_rd_i = '0;
    logic        kill_i = 1'b0;
    logic        ld_resp_valid_i = 1'b0;
    logic [63:0] ld_resp_rdata_i = '0;
    logic        resp_valid_o;
    logic [63:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        dmem_lock_o;
    logic        spurious_o;

    lagarto_ld_resp_unit #(.DEPTH(4)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .ld_issue_valid_i  (ld_issue_valid_i),
        .ld_issue_ready_o  (ld_issue_ready_o),
        .ld_issue_offset_i (ld_issue_offset_i),
        .ld_issue_size_i   (ld_issue_size_i),
        .ld_issue_signed_i (ld_issue_signed_i),
        .ld_issue_rd_i     (ld_issue_rd_i),
        .kill_i            (kill_i),
        .ld_resp_valid_i   (ld_resp_valid_i),
        .ld_resp_rdata_i   (ld_resp_rdata_i),
        .resp_valid_o      (resp_valid_o),
        .resp_data_o       (resp_data_o),
        .resp_rd_o         (resp_rd_o),
        .dmem_lock_o       (dmem_lock_o),
        .spurious_o        (spurious_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (resp_valid_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got rd %0d data 0x%016h expected no result (t=%0t)",
                         resp_rd_o, resp_data_o, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rd", 64'(resp_rd_o), 64'(e.rd));
                chk("resp_data", resp_data_o, e.data);
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [2:0] off, input logic [1:0] sz, input logic sg, input logic [4:0] rd);
        ld_issue_valid_i  = 1'b1;
        ld_issue_offset_i = off;
        ld_issue_size_i   = sz;
        ld_issue_signed_i = sg;
        ld_issue_rd_i     = rd;
        tick();
        ld_issue_valid_i  = 1'b0;
    endtask

    // expect_it=0 means the response must be swallowed (killed entry or nothing pending).
    task automatic respond(input logic [63:0] rdata, input bit expect_it,
                           input logic [4:0] rd, input logic [63:0] data);
        exp_t e;
        if (expect_it) begin
            e.rd = rd; e.data = data; e.cyc = cyc + 1;
            sb.push_back(e);
        end
        ld_resp_valid_i = 1'b1;
        ld_resp_rdata_i = rdata;
        tick();
        ld_resp_valid_i = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_data", resp_data_o, 64'd0);
        chk("rst_ready", 64'(ld_issue_ready_o), 64'd1);
        chk("rst_lock", 64'(dmem_lock_o), 64'd0);
        chk("rst_spurious", 64'(spurious_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // LB offset 3: byte 0x80 sign-extends
        issue(3'd3, 2'd0, 1'b1, 5'd5);
        chk("lock_one_pending", 64'(dmem_lock_o), 64'd1);
        respond(64'h0000_0000_8000_0000, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80);

        // LWU / LW offset 4, then LHU offset 2, LH offset 6, LD offset 0
        issue(3'd4, 2'd2, 1'b0, 5'd6);
        issue(3'd4, 2'd2, 1'b1, 5'd7);
        respond(64'h8765_4321_0000_0000, 1'b1, 5'd6, 64'h0000_0000_8765_4321);
        respond(64'h8765_4321_0000_0000, 1'b1, 5'd7, 64'hFFFF_FFFF_8765_4321);
        issue(3'd2, 2'd1, 1'b0, 5'd9);
        issue(3'd6, 2'd1, 1'b1, 5'd10);
        issue(3'd0, 2'd3, 1'b1, 5'd11);
        respond(64'h1122_3344_5566_F788, 1'b1, 5'd9,  64'h0000_0000_0000_5566);
        respond(64'h8001_0000_0000_0000, 1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_8001);
        respond(64'hDEAD_BEEF_0123_4567, 1'b1, 5'd11, 64'hDEAD_BEEF_0123_4567);
        tick();
        chk("lock_after_drain", 64'(dmem_lock_o), 64'd0);

        // Fill to DEPTH, extra issue ignored (also while a pop happens in the same cycle)
        for (int i = 0; i < 4; i++) issue(3'd0, 2'd2, 1'b0, 5'(12 + i));
        chk("full_ready", 64'(ld_issue_ready_o), 64'd0);
        chk("full_lock", 64'(dmem_lock_o), 64'd1);
        ld_issue_valid_i = 1'b1;
        ld_issue_rd_i    = 5'd20;
        tick();
        chk("full_ready_hold", 64'(ld_issue_ready_o), 64'd0);
        respond(64'hA5A5_0000_0000_0010, 1'b1, 5'd12, 64'h0000_0000_0000_0010);
        ld_issue_valid_i = 1'b0;
        chk("ready_after_pop", 64'(ld_issue_ready_o), 64'd1);
        for (int i = 1; i < 4; i++)
            respond(64'hA5A5_0000_0000_0010 + 64'(i), 1'b1, 5'(12 + i), 64'h10 + 64'(i));
        tick();
        chk("full_lock_released", 64'(dmem_lock_o), 64'd0);

        // Two pending, kill with simultaneous response: both discarded
        issue(3'd0, 2'd3, 1'b0, 5'd21);
        issue(3'd0, 2'd3, 1'b0, 5'd22);
        kill_i = 1'b1;
        ld_issue_valid_i = 1'b1;
        ld_issue_rd_i    = 5'd23;
        respond(64'h1111_2222_3333_4444, 1'b0, 5'd0, 64'd0);
        kill_i = 1'b0;
        ld_issue_valid_i = 1'b0;
        chk("kill_lock_mid", 64'(dmem_lock_o), 64'd1);
        respond(64'h5555_6666_7777_8888, 1'b0, 5'd0, 64'd0);
        chk("kill_lock_released", 64'(dmem_lock_o), 64'd0);
        chk("kill_no_spurious", 64'(spurious_o), 64'd0);

        // Response with nothing pending
        respond(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 64'd0);
        chk("spurious_set", 64'(spurious_o), 64'd1);
        chk("spurious_lock", 64'(dmem_lock_o), 64'd0);
        tick();
        chk("spurious_sticky", 64'(spurious_o), 64'd1);

        // Reset mid-flight with 3 pending and a result on the outputs
        for (int i = 0; i < 4; i++) issue(3'd0, 2'd0, 1'b0, 5'(24 + i));
        respond(64'h0000_0000_0000_00AB, 1'b1, 5'd24, 64'h0000_0000_0000_00AB);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("midrst_resp_data", resp_data_o, 64'd0);
        chk("midrst_resp_rd", 64'(resp_rd_o), 64'd0);
        chk("midrst_lock", 64'(dmem_lock_o), 64'd0);
        chk("midrst_ready", 64'(ld_issue_ready_o), 64'd1);
        chk("midrst_spurious", 64'(spurious_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        respond(64'h0000_0000_0000_00CD, 1'b0, 5'd0, 64'd0);
        chk("post_rst_spurious", 64'(spurious_o), 64'd1);

        // Normal operation after reset
        issue(3'd1, 2'd0, 1'b0, 5'd30);
        respond(64'h0000_0000_0000_EE00, 1'b1, 5'd30, 64'h0000_0000_0000_00EE);
        tick();
        tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
